// File: rtl/raster_pixel_gen_pkg.sv
// Shared types for the raster source: FSM states, pattern codes and the
// colour-bar palette used by the built-in test pattern generator.
package raster_pixel_gen_pkg;

    localparam int CW    = 13;
    localparam int BAR_W = 80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_EXT   = 2'd0,
        SEL_BARS  = 2'd1,
        SEL_CHECK = 2'd2,
        SEL_RAMP  = 2'd3
    } sel_t;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [0:7][23:0] BAR_RGB = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/raster_pattern.sv
// Combinational test pattern: maps (col, x_count, sel) to {R,G,B}.
// Ports: col/x_count raster position, sel pattern code, rgb pixel out.
module raster_pattern
    import raster_pixel_gen_pkg::*;
(
    input  logic [CW-1:0] col,
    input  logic [CW-1:0] x_count,
    input  sel_t          sel,
    output logic [23:0]   rgb
);

    logic [2:0] bar;
    logic       chk;
    logic       unused_x;

    assign chk      = col[5] ^ x_count[5];
    assign unused_x = ^{x_count[CW-1:6], x_count[4:0]};

    // Bar index col/80 as a compare ladder, scanning from the right edge.
    always_comb begin
        bar = 3'd7;
        for (int i = 7; i >= 0; i--) begin
            if (col < CW'((i + 1) * BAR_W)) bar = 3'(i);
        end
    end

    always_comb begin
        rgb = '0;
        unique case (sel)
            SEL_BARS:  rgb = BAR_RGB[bar];
            SEL_CHECK: rgb = {24{chk}};
            SEL_RAMP:  rgb = {3{col[9:2]}};
            default:   rgb = '0;
        endcase
    end

endmodule

// File: rtl/raster_pixel_gen.sv
// VGA raster source: timing counters, syncs, de and a 24-bit pixel stream.
// Ports: clk/reset, en run request, pattern_sel, ext_req/ext_rgb fetch,
// col/x_count position, de/hsync/vsync/frame_start, r/g/b, busy.
// Build option RASTER_PATTERN_EN compiles in the test pattern generator.
module raster_pixel_gen
    import raster_pixel_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    pattern_sel,
    output logic          ext_req,
    input  logic [23:0]   ext_rgb,
    output logic [CW-1:0] col,
    output logic [CW-1:0] x_count,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start,
    output logic [7:0]    r,
    output logic [7:0]    g,
    output logic [7:0]    b,
    output logic          busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_B  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_E  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_B  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_E  = CW'(V_ACTIVE + V_FP + V_SYNC);

    state_t        state_q, state_d;
    logic [CW-1:0] col_d, x_d;
    logic          line_end, frame_end;
    logic          live_d, de_d, fs_d;
    logic [23:0]   pix;

    always_comb begin
        state_d   = state_q;
        col_d     = '0;
        x_d       = '0;
        line_end  = (col == H_LST);
        frame_end = line_end && (x_count == V_LST);
        unique case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN, ST_DRAIN: begin
                col_d = line_end ? '0 : col + 1'b1;
                x_d   = !line_end ? x_count
                      : frame_end ? '0 : x_count + 1'b1;
                // Without en the frame still runs to its last pixel.
                if (en)             state_d = ST_RUN;
                else if (frame_end) state_d = ST_IDLE;
                else                state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign live_d = (state_d != ST_IDLE);
    assign de_d   = live_d && (col_d < H_ACT) && (x_d < V_ACT);
    assign fs_d   = live_d && (col_d == '0) && (x_d == '0);

    // Fetch strobe is the next cycle's de, so data can arrive with de.
    assign ext_req = de_d && !reset;
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col         <= '0;
            x_count     <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            col         <= col_d;
            x_count     <= x_d;
            de          <= de_d;
            hsync       <= !(live_d && col_d >= HS_B && col_d < HS_E);
            vsync       <= !(live_d && x_d >= VS_B && x_d < VS_E);
            frame_start <= fs_d;
        end
    end

`ifdef RASTER_PATTERN_EN
    sel_t        sel_q, sel_eff;
    logic [23:0] pat_rgb, pat_q;

    // Selection is taken at frame start so a frame never tears.
    assign sel_eff = fs_d ? sel_t'(pattern_sel) : sel_q;

    raster_pattern u_pattern (
        .col     (col_d),
        .x_count (x_d),
        .sel     (sel_eff),
        .rgb     (pat_rgb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q <= SEL_EXT;
            pat_q <= '0;
        end else begin
            sel_q <= sel_eff;
            pat_q <= pat_rgb;
        end
    end

    // External data is presented during its de cycle and passes through.
    assign pix = (sel_q == SEL_EXT) ? ext_rgb : pat_q;
`else
    logic unused_sel;

    assign unused_sel = ^pattern_sel;
    assign pix        = ext_rgb;
`endif

    assign {r, g, b} = de ? pix : 24'h0;

endmodule

// File: tb/tb_raster_pixel_gen.sv
// Directed bench for raster_pixel_gen with a short vertical raster
// (800 x 10 total) so whole frames fit in a small cycle budget.
module tb_raster_pixel_gen;

    localparam int HT = 800;
    localparam int VT = 10;
    localparam int VA = 6;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [1:0]  pattern_sel;
    logic [23:0] ext_rgb;
    logic        ext_req, de, hsync, vsync, frame_start, busy;
    logic [12:0] col, x_count;
    logic [7:0]  r, g, b;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   ec    = 0;
    int   ex    = 0;
    logic prev_req;

    raster_pixel_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(VA),  .V_FP(1),  .V_SYNC(2),  .V_BP(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .pattern_sel (pattern_sel),
        .ext_req     (ext_req),
        .ext_rgb     (ext_rgb),
        .col         (col),
        .x_count     (x_count),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .r           (r),
        .g           (g),
        .b           (b),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [23:0] ext_val(int c);
        return 24'(c * 37 + 256);
    endfunction

    task automatic step();
        prev_req = ext_req;
        @(negedge clk);
        cyc++;
        ext_rgb = ext_val(cyc);
        #1;
    endtask

    task automatic adv();
        step();
        if (ec == HT - 1) begin
            ec = 0;
            ex = (ex == VT - 1) ? 0 : ex + 1;
        end else begin
            ec++;
        end
    endtask

    task automatic goto(int c, int l);
        int n = 0;
        do begin
            adv();
            n++;
        end while (!(ec == c && ex == l) && n <= HT * VT);
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; pattern_sel = 2'd0; ext_rgb = '0;
        repeat (3) @(negedge clk);
        #1;
        tests++; if (col !== 13'd0) begin fails++;
            $display("FAIL rst_col: got %0d want 0", col); end
        tests++; if (x_count !== 13'd0) begin fails++;
            $display("FAIL rst_x: got %0d want 0", x_count); end
        tests++; if ({de, frame_start, busy, ext_req} !== 4'b0) begin fails++;
            $display("FAIL rst_flags: got %b want 0000",
                     {de, frame_start, busy, ext_req}); end
        tests++; if ({hsync, vsync} !== 2'b11) begin fails++;
            $display("FAIL rst_sync: got %b want 11", {hsync, vsync}); end
        tests++; if ({r, g, b} !== 24'h0) begin fails++;
            $display("FAIL rst_rgb: got %h want 0", {r, g, b}); end
        reset = 1'b0;
        step();
        tests++; if (busy !== 1'b0 || col !== 13'd0) begin fails++;
            $display("FAIL idle_hold: busy %b col %0d want 0 0", busy, col); end
    endtask

    task automatic test_frame();
        int e_pos = 0, e_de = 0, e_hs = 0, e_vs = 0;
        int e_fs = 0, e_pix = 0, e_req = 0, n_de = 0, n_fs = 0;
        logic exp_de;
        en = 1'b1;
        #1;
        tests++; if (ext_req !== 1'b1) begin fails++;
            $display("FAIL first_req: got %b want 1", ext_req); end
        step();
        ec = 0; ex = 0;
        tests++; if (frame_start !== 1'b1 || busy !== 1'b1) begin fails++;
            $display("FAIL start: fs %b busy %b want 1 1", frame_start, busy); end
        for (int i = 0; i < HT * VT; i++) begin
            exp_de = (ec < 640) && (ex < VA);
            if (col !== 13'(ec) || x_count !== 13'(ex)) e_pos++;
            if (de !== exp_de) e_de++;
            if (de === 1'b1) n_de++;
            if (hsync !== !(ec >= 656 && ec < 752)) e_hs++;
            if (vsync !== !(ex >= VA + 1 && ex < VA + 3)) e_vs++;
            if (frame_start !== (ec == 0 && ex == 0)) e_fs++;
            if (frame_start === 1'b1) n_fs++;
            if ({r, g, b} !== (exp_de ? ext_val(cyc) : 24'h0)) e_pix++;
            if (prev_req !== exp_de) e_req++;
            adv();
        end
        tests++; if (frame_start !== 1'b1 || col !== 13'd0 || x_count !== 13'd0)
            begin fails++;
            $display("FAIL wrap: fs %b col %0d x %0d want 1 0 0",
                     frame_start, col, x_count); end
        tests++; if (e_pos !== 0) begin fails++;
            $display("FAIL position: %0d bad cycles want 0", e_pos); end
        tests++; if (e_de !== 0 || n_de !== 640 * VA) begin fails++;
            $display("FAIL de: %0d bad, %0d high want 0, %0d", e_de, n_de, 640 * VA); end
        tests++; if (e_hs !== 0) begin fails++;
            $display("FAIL hsync: %0d bad cycles want 0", e_hs); end
        tests++; if (e_vs !== 0) begin fails++;
            $display("FAIL vsync: %0d bad cycles want 0", e_vs); end
        tests++; if (e_fs !== 0 || n_fs !== 1) begin fails++;
            $display("FAIL frame_start: %0d bad, %0d pulses want 0, 1", e_fs, n_fs); end
        tests++; if (e_pix !== 0) begin fails++;
            $display("FAIL ext_pixel: %0d bad cycles want 0", e_pix); end
        tests++; if (e_req !== 0) begin fails++;
            $display("FAIL ext_req: %0d bad cycles want 0", e_req); end
    endtask

`ifdef RASTER_PATTERN_EN
    task automatic test_patterns();
        pattern_sel = 2'd1;
        goto(80, 1);
        tests++; if ({r, g, b} !== ext_val(cyc)) begin fails++;
            $display("FAIL sel_hold_ext: got %h want %h", {r, g, b}, ext_val(cyc)); end
        goto(0, 0);
        tests++; if ({r, g, b} !== 24'hFFFFFF) begin fails++;
            $display("FAIL bar_c0: got %h want FFFFFF", {r, g, b}); end
        goto(80, 0);
        tests++; if ({r, g, b} !== 24'hFFFF00) begin fails++;
            $display("FAIL bar_c80: got %h want FFFF00", {r, g, b}); end
        goto(480, 0);
        tests++; if ({r, g, b} !== 24'h0000FF) begin fails++;
            $display("FAIL bar_c480: got %h want 0000FF", {r, g, b}); end
        goto(639, 0);
        tests++; if ({r, g, b} !== 24'h000000) begin fails++;
            $display("FAIL bar_c639: got %h want 000000", {r, g, b}); end
        pattern_sel = 2'd2;
        goto(160, 1);
        tests++; if ({r, g, b} !== 24'h00FFFF) begin fails++;
            $display("FAIL bar_hold: got %h want 00FFFF", {r, g, b}); end
        goto(32, 0);
        tests++; if ({r, g, b} !== 24'hFFFFFF) begin fails++;
            $display("FAIL chk_c32: got %h want FFFFFF", {r, g, b}); end
        goto(64, 0);
        tests++; if ({r, g, b} !== 24'h000000) begin fails++;
            $display("FAIL chk_c64: got %h want 000000", {r, g, b}); end
        pattern_sel = 2'd3;
        goto(100, 0);
        tests++; if ({r, g, b} !== 24'hFFFFFF) begin fails++;
            $display("FAIL chk_hold: got %h want FFFFFF", {r, g, b}); end
        goto(0, 0);
        goto(100, 0);
        tests++; if ({r, g, b} !== 24'h191919) begin fails++;
            $display("FAIL ramp_c100: got %h want 191919", {r, g, b}); end
        goto(639, 0);
        tests++; if ({r, g, b} !== 24'h9F9F9F) begin fails++;
            $display("FAIL ramp_c639: got %h want 9F9F9F", {r, g, b}); end
        goto(700, 0);
        tests++; if ({r, g, b} !== 24'h0) begin fails++;
            $display("FAIL ramp_blank: got %h want 0", {r, g, b}); end
        pattern_sel = 2'd0;
        goto(0, 0);
    endtask
`else
    task automatic test_patterns();
        pattern_sel = 2'd1;
        goto(0, 0);
        goto(80, 0);
        tests++; if ({r, g, b} !== ext_val(cyc)) begin fails++;
            $display("FAIL sel_ignored: got %h want %h", {r, g, b}, ext_val(cyc)); end
        pattern_sel = 2'd0;
    endtask
`endif

    task automatic test_drain();
        goto(0, 2);
        en = 1'b0;
        adv();
        tests++; if (busy !== 1'b1 || col !== 13'd1) begin fails++;
            $display("FAIL drain_enter: busy %b col %0d want 1 1", busy, col); end
        goto(0, 3);
        tests++; if (de !== 1'b1) begin fails++;
            $display("FAIL drain_de: got %b want 1", de); end
        goto(0, 4);
        en = 1'b1;
        goto(0, 0);
        tests++; if (frame_start !== 1'b1 || busy !== 1'b1) begin fails++;
            $display("FAIL drain_resume: fs %b busy %b want 1 1", frame_start, busy); end
        goto(0, 3);
        en = 1'b0;
        goto(HT - 1, VT - 1);
        tests++; if (busy !== 1'b1 || x_count !== 13'(VT - 1)) begin fails++;
            $display("FAIL drain_last: busy %b x %0d want 1 %0d", busy, x_count, VT - 1); end
        step();
        tests++; if ({busy, de, frame_start, ext_req} !== 4'b0) begin fails++;
            $display("FAIL drain_idle: got %b want 0000",
                     {busy, de, frame_start, ext_req}); end
        tests++; if (col !== 13'd0 || x_count !== 13'd0 || hsync !== 1'b1) begin fails++;
            $display("FAIL idle_out: col %0d x %0d hs %b want 0 0 1", col, x_count, hsync); end
        repeat (5) step();
        tests++; if (col !== 13'd0 || busy !== 1'b0) begin fails++;
            $display("FAIL idle_stay: col %0d busy %b want 0 0", col, busy); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        step();
        ec = 0; ex = 0;
        tests++; if (frame_start !== 1'b1 || col !== 13'd0) begin fails++;
            $display("FAIL restart: fs %b col %0d want 1 0", frame_start, col); end
        goto(300, 0);
        tests++; if (col !== 13'd300 || de !== 1'b1) begin fails++;
            $display("FAIL pre_reset: col %0d de %b want 300 1", col, de); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (col !== 13'd0 || {de, busy, frame_start, ext_req} !== 4'b0)
            begin fails++;
            $display("FAIL async_reset: col %0d flags %b want 0 0000",
                     col, {de, busy, frame_start, ext_req}); end
        tests++; if ({hsync, vsync} !== 2'b11 || {r, g, b} !== 24'h0) begin fails++;
            $display("FAIL async_reset_out: sync %b rgb %h want 11 0",
                     {hsync, vsync}, {r, g, b}); end
        step();
        reset = 1'b0;
        step();
        tests++; if (frame_start !== 1'b1 || col !== 13'd0 || busy !== 1'b1)
            begin fails++;
            $display("FAIL post_reset: fs %b col %0d busy %b want 1 0 1",
                     frame_start, col, busy); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_patterns();
        test_drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
